// File: rtl/xif_mac_accel_pkg.sv
// Shared types and decode constants for the custom-0 MAC coprocessor.
package xif_mac_accel_pkg;

    typedef enum logic [1:0] {
        OpMac    = 2'd0,
        OpAccRd  = 2'd1,
        OpAccClr = 2'd2,
        OpAdds   = 2'd3
    } xif_mac_op_e;

    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StWaitCommit = 2'd1,
        StExec       = 2'd2,
        StResult     = 2'd3
    } xif_mac_state_e;

    localparam logic [6:0] XifMacOpcode   = 7'b0001011;
    localparam logic [2:0] Funct3Mac      = 3'b000;
    localparam logic [2:0] Funct3AccRd    = 3'b001;
    localparam logic [2:0] Funct3AccClr   = 3'b010;
    localparam logic [2:0] Funct3Adds     = 3'b011;

    // Signed saturating add: overflow only when both signs agree and the sum's sign differs.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] sum;
        sum = a + b;
        if ((a[31] == b[31]) && (sum[31] != a[31])) begin
            sat_add = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/xif_mac_accel_if.sv
// X-interface issue/commit/result channels between core (master) and coprocessor (slave).
interface xif_mac_accel_if #(
    parameter int unsigned IdWidth = 4
);
    logic               issue_valid;
    logic               issue_ready;
    logic [31:0]        issue_instr;
    logic [31:0]        issue_rs1;
    logic [31:0]        issue_rs2;
    logic [1:0]         issue_rs_valid;
    logic [IdWidth-1:0] issue_id;
    logic               issue_accept;
    logic               issue_writeback;
    logic               commit_valid;
    logic [IdWidth-1:0] commit_id;
    logic               commit_kill;
    logic               result_valid;
    logic               result_ready;
    logic [IdWidth-1:0] result_id;
    logic [31:0]        result_data;
    logic [4:0]         result_rd;
    logic               result_we;

    modport master (
        output issue_valid, issue_instr, issue_rs1, issue_rs2, issue_rs_valid, issue_id,
        input  issue_ready, issue_accept, issue_writeback,
        output commit_valid, commit_id, commit_kill,
        input  result_valid, result_id, result_data, result_rd, result_we,
        output result_ready
    );

    modport slave (
        input  issue_valid, issue_instr, issue_rs1, issue_rs2, issue_rs_valid, issue_id,
        output issue_ready, issue_accept, issue_writeback,
        input  commit_valid, commit_id, commit_kill,
        output result_valid, result_id, result_data, result_rd, result_we,
        input  result_ready
    );
endinterface

// File: rtl/xif_mac_mul_iter.sv
// Iterative shift-add multiplier, MulUnroll multiplier bits per cycle, low 32-bit product.
module xif_mac_mul_iter #(
    parameter int unsigned MulUnroll = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_product
);
    localparam int unsigned Iter = 32 / MulUnroll;
    localparam int unsigned CntW = $clog2(Iter);

    logic [31:0]     r_mcand;
    logic [31:0]     r_mplier;
    logic [31:0]     r_prod;
    logic [CntW-1:0] r_cnt;
    logic            r_busy;
    logic [31:0]     w_partial;
    logic [31:0]     w_sum;
    logic            w_last;

    always_comb begin
        w_partial = '0;
        for (int j = 0; j < MulUnroll; j++) begin
            if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
        end
    end

    assign w_sum  = r_prod + w_partial;
    assign w_last = (r_cnt == CntW'(Iter - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_mcand  <= r_mcand << MulUnroll;
            r_mplier <= r_mplier >> MulUnroll;
            r_prod   <= w_sum;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) r_busy <= 1'b0;
        end
    end

    // Final product is presented combinationally in the last busy cycle.
    assign o_busy    = r_busy;
    assign o_done    = r_busy && w_last;
    assign o_product = w_sum;

endmodule

// File: rtl/xif_mac_accel.sv
// CV-X-IF coprocessor executing custom-0 MAC/accumulator ops, one instruction in flight.
module xif_mac_accel
    import xif_mac_accel_pkg::*;
#(
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned MulUnroll = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    xif_mac_accel_if.slave x
);
    xif_mac_state_e     r_state, w_state_nxt;
    xif_mac_op_e        r_op;
    logic [31:0]        r_rs1, r_rs2, r_acc, r_res;
    logic [IdWidth-1:0] r_id;
    logic [4:0]         r_rd;

    xif_mac_op_e        w_dec_op, w_op_cur;
    logic               w_ours, w_need_ops, w_ops_ok, w_idle, w_hs, w_commit;
    logic [31:0]        w_rs1_cur, w_rs2_cur, w_acc_nxt, w_res_nxt, w_mul_prod;
    logic [IdWidth-1:0] w_id_cur;
    logic               w_mul_start, w_mul_done, w_mul_busy;
    logic               w_unused;

    always_comb begin
        w_ours   = 1'b0;
        w_dec_op = OpMac;
        if (x.issue_instr[6:0] == XifMacOpcode && x.issue_instr[31:25] == 7'd0) begin
            case (x.issue_instr[14:12])
                Funct3Mac:    begin w_ours = 1'b1; w_dec_op = OpMac;    end
                Funct3AccRd:  begin w_ours = 1'b1; w_dec_op = OpAccRd;  end
                Funct3AccClr: begin w_ours = 1'b1; w_dec_op = OpAccClr; end
                Funct3Adds:   begin w_ours = 1'b1; w_dec_op = OpAdds;   end
                default:      ;
            endcase
        end
    end

    assign w_need_ops = (w_dec_op == OpMac) || (w_dec_op == OpAdds);
    assign w_ops_ok   = !w_need_ops || (x.issue_rs_valid == 2'b11);
    assign w_idle     = (r_state == StIdle);

    assign x.issue_ready     = !rst_i && w_idle && !(w_ours && !w_ops_ok);
    assign x.issue_accept    = !rst_i && w_idle && x.issue_valid && w_ours;
    assign x.issue_writeback = x.issue_accept;
    assign w_hs              = x.issue_accept && x.issue_ready;

    // During the handshake cycle the live issue fields stand in for the latched ones.
    assign w_op_cur  = w_idle ? w_dec_op    : r_op;
    assign w_rs1_cur = w_idle ? x.issue_rs1 : r_rs1;
    assign w_rs2_cur = w_idle ? x.issue_rs2 : r_rs2;
    assign w_id_cur  = w_idle ? x.issue_id  : r_id;
    assign w_commit  = x.commit_valid && (x.commit_id == w_id_cur) &&
                       (w_hs || r_state == StWaitCommit);

    always_comb begin
        w_state_nxt = r_state;
        w_mul_start = 1'b0;
        w_acc_nxt   = r_acc;
        w_res_nxt   = r_res;
        unique case (r_state)
            StIdle:       if (w_hs) w_state_nxt = StWaitCommit;
            StWaitCommit: ;
            StExec: begin
                if (w_mul_done) begin
                    w_acc_nxt   = r_acc + w_mul_prod;
                    w_res_nxt   = r_acc + w_mul_prod;
                    w_state_nxt = StResult;
                end
            end
            StResult:     if (x.result_ready) w_state_nxt = StIdle;
        endcase
        if (w_commit) begin
            if (x.commit_kill) begin
                w_state_nxt = StIdle;
            end else if (w_op_cur == OpMac) begin
                w_state_nxt = StExec;
                w_mul_start = 1'b1;
            end else begin
                w_state_nxt = StResult;
                unique case (w_op_cur)
                    OpAccRd:  w_res_nxt = r_acc;
                    OpAccClr: begin w_res_nxt = r_acc; w_acc_nxt = '0; end
                    OpAdds:   w_res_nxt = sat_add(w_rs1_cur, w_rs2_cur);
                    OpMac:    ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_op    <= OpMac;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_id    <= '0;
            r_rd    <= '0;
            r_acc   <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_res   <= w_res_nxt;
            if (w_hs) begin
                r_op  <= w_dec_op;
                r_rs1 <= x.issue_rs1;
                r_rs2 <= x.issue_rs2;
                r_id  <= x.issue_id;
                r_rd  <= x.issue_instr[11:7];
            end
        end
    end

    xif_mac_mul_iter #(
        .MulUnroll (MulUnroll)
    ) u_mul (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_start   (w_mul_start),
        .i_a       (w_rs1_cur),
        .i_b       (w_rs2_cur),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    assign x.result_valid = (r_state == StResult);
    assign x.result_we    = x.result_valid;
    assign x.result_data  = x.result_valid ? r_res : '0;
    assign x.result_id    = x.result_valid ? r_id  : '0;
    assign x.result_rd    = x.result_valid ? r_rd  : '0;

    assign w_unused = ^{x.issue_instr[24:15], w_mul_busy};

endmodule

// File: tb/tb_xif_mac_accel.sv
// Directed self-checking bench for xif_mac_accel with hand-computed expected results.
module tb_xif_mac_accel;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    xif_mac_accel_if #(.IdWidth(4)) x_if ();

    xif_mac_accel #(
        .IdWidth   (4),
        .MulUnroll (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .x     (x_if)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
        return {7'd0, 10'd0, f3, rd, 7'b0001011};
    endfunction

    task automatic issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [3:0] id);
        logic ok;
        ok = 1'b0;
        x_if.issue_valid    = 1'b1;
        x_if.issue_instr    = instr;
        x_if.issue_rs1      = rs1;
        x_if.issue_rs2      = rs2;
        x_if.issue_rs_valid = 2'b11;
        x_if.issue_id       = id;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (x_if.issue_ready) begin
                check_eq("issue_accept", 32'(x_if.issue_accept), 32'd1);
                check_eq("issue_writeback", 32'(x_if.issue_writeback), 32'd1);
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check_eq("issue_ready_timeout", 32'(x_if.issue_ready), 32'd1);
        @(posedge clk); #1;
        x_if.issue_valid = 1'b0;
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        x_if.commit_valid = 1'b1;
        x_if.commit_id    = id;
        x_if.commit_kill  = kill;
        @(posedge clk); #1;
        x_if.commit_valid = 1'b0;
        x_if.commit_kill  = 1'b0;
    endtask

    // Latency counts cycles after the commit cycle until result_valid is seen.
    task automatic wait_result(input string tag, input logic [31:0] exp_data,
                               input logic [3:0] exp_id, input logic [4:0] exp_rd,
                               input int exp_lat);
        int lat;
        lat = 1;
        while (!x_if.result_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_valid"}, 32'(x_if.result_valid), 32'd1);
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_data"}, x_if.result_data, exp_data);
        check_eq({tag, "_id"}, 32'(x_if.result_id), 32'(exp_id));
        check_eq({tag, "_rd"}, 32'(x_if.result_rd), 32'(exp_rd));
        check_eq({tag, "_we"}, 32'(x_if.result_we), 32'd1);
        if (x_if.result_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [3:0] id,
                          input logic [31:0] exp_data, input int exp_lat);
        issue(mk(f3, rd), rs1, rs2, id);
        commit(id, 1'b0);
        wait_result(tag, exp_data, id, rd, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] d0;
        x_if.issue_valid    = 1'b0;
        x_if.issue_instr    = '0;
        x_if.issue_rs1      = '0;
        x_if.issue_rs2      = '0;
        x_if.issue_rs_valid = 2'b00;
        x_if.issue_id       = '0;
        x_if.commit_valid   = 1'b0;
        x_if.commit_id      = '0;
        x_if.commit_kill    = 1'b0;
        x_if.result_ready   = 1'b1;

        #1;
        check_eq("rst_ready_low", 32'(x_if.issue_ready), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(x_if.issue_ready), 32'd1);
        check_eq("post_rst_rvalid", 32'(x_if.result_valid), 32'd0);
        check_eq("post_rst_accept", 32'(x_if.issue_accept), 32'd0);
        check_eq("post_rst_wb", 32'(x_if.issue_writeback), 32'd0);
        @(posedge clk); #1;

        run_op("accclr0", 3'b010, 5'd1, 32'd0, 32'd0, 4'd0, 32'd0, 1);
        run_op("mac1", 3'b000, 5'd2, 32'd3, 32'd5, 4'd1, 32'd15, 9);
        run_op("mac2", 3'b000, 5'd3, 32'h0000_FFFF, 32'h0001_0001, 4'd2, 32'd14, 9);
        run_op("adds_pos", 3'b011, 5'd4, 32'h7FFF_FFF0, 32'h0000_0100, 4'd3,
               32'h7FFF_FFFF, 1);
        run_op("adds_neg", 3'b011, 5'd5, 32'h8000_0001, 32'hFFFF_FFF0, 4'd4,
               32'h8000_0000, 1);
        run_op("adds_nosat", 3'b011, 5'd5, 32'hFFFF_FFFE, 32'd5, 4'd4, 32'd3, 1);
        run_op("accrd_after_adds", 3'b001, 5'd6, 32'd0, 32'd0, 4'd5, 32'd14, 1);

        // Non-matching commit ignored, then matching kill discards the MAC.
        issue(mk(3'b000, 5'd7), 32'd100, 32'd100, 4'd3);
        commit(4'd5, 1'b0);
        @(posedge clk); #1;
        check_eq("wrong_id_no_result", 32'(x_if.result_valid), 32'd0);
        check_eq("wrong_id_ready", 32'(x_if.issue_ready), 32'd0);
        commit(4'd3, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check_eq("kill_no_result", 32'(x_if.result_valid), 32'd0);
            @(posedge clk); #1;
        end
        check_eq("kill_idle_ready", 32'(x_if.issue_ready), 32'd1);
        run_op("accrd_after_kill", 3'b001, 5'd8, 32'd0, 32'd0, 4'd6, 32'd14, 1);

        // Result back-pressure.
        x_if.result_ready = 1'b0;
        issue(mk(3'b001, 5'd9), 32'd0, 32'd0, 4'd7);
        commit(4'd7, 1'b0);
        wait_result("bp", 32'd14, 4'd7, 5'd9, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("bp_valid", 32'(x_if.result_valid), 32'd1);
            check_eq("bp_data", x_if.result_data, 32'd14);
            check_eq("bp_id", 32'(x_if.result_id), 32'd7);
            check_eq("bp_rd", 32'(x_if.result_rd), 32'd9);
            check_eq("bp_issue_ready", 32'(x_if.issue_ready), 32'd0);
        end
        x_if.result_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_released", 32'(x_if.result_valid), 32'd0);

        // Foreign instructions: not accepted, FSM stays idle.
        x_if.issue_valid    = 1'b1;
        x_if.issue_instr    = 32'h0000_0033;
        x_if.issue_rs_valid = 2'b00;
        #1;
        check_eq("foreign_accept", 32'(x_if.issue_accept), 32'd0);
        check_eq("foreign_wb", 32'(x_if.issue_writeback), 32'd0);
        check_eq("foreign_ready", 32'(x_if.issue_ready), 32'd1);
        @(posedge clk); #1;
        x_if.issue_instr = mk(3'b111, 5'd1);
        #1;
        check_eq("f3_111_accept", 32'(x_if.issue_accept), 32'd0);
        check_eq("f3_111_wb", 32'(x_if.issue_writeback), 32'd0);
        @(posedge clk); #1;
        check_eq("f3_111_idle", 32'(x_if.issue_ready), 32'd1);
        check_eq("f3_111_no_result", 32'(x_if.result_valid), 32'd0);

        // MAC stalls until both operands are valid; killed afterwards to keep acc.
        x_if.issue_instr    = mk(3'b000, 5'd2);
        x_if.issue_rs_valid = 2'b01;
        x_if.issue_id       = 4'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_ready", 32'(x_if.issue_ready), 32'd0);
            @(posedge clk); #1;
        end
        x_if.issue_rs_valid = 2'b11;
        #1;
        check_eq("unstall_ready", 32'(x_if.issue_ready), 32'd1);
        check_eq("unstall_accept", 32'(x_if.issue_accept), 32'd1);
        @(posedge clk); #1;
        x_if.issue_valid = 1'b0;
        commit(4'd9, 1'b1);
        check_eq("stall_kill_idle", 32'(x_if.issue_ready), 32'd1);

        // Commit in the same cycle as the issue handshake.
        x_if.issue_valid    = 1'b1;
        x_if.issue_instr    = mk(3'b001, 5'd11);
        x_if.issue_id       = 4'd2;
        x_if.commit_valid   = 1'b1;
        x_if.commit_id      = 4'd2;
        x_if.commit_kill    = 1'b0;
        @(posedge clk); #1;
        x_if.issue_valid  = 1'b0;
        x_if.commit_valid = 1'b0;
        wait_result("same_cycle", 32'd14, 4'd2, 5'd11, 1);

        // Reset mid-EXEC aborts everything and clears acc.
        issue(mk(3'b000, 5'd12), 32'd2, 32'd2, 4'd4);
        commit(4'd4, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("exec_busy_ready", 32'(x_if.issue_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        d0 = x_if.result_data;
        check_eq("async_rst_rvalid", 32'(x_if.result_valid), 32'd0);
        check_eq("async_rst_ready", 32'(x_if.issue_ready), 32'd0);
        check_eq("async_rst_accept", 32'(x_if.issue_accept), 32'd0);
        check_eq("async_rst_data", d0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("rst_release_ready", 32'(x_if.issue_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check_eq("rst_no_result", 32'(x_if.result_valid), 32'd0);
        end
        run_op("accrd_after_rst", 3'b001, 5'd13, 32'd0, 32'd0, 4'd8, 32'd0, 1);
        run_op("mac_after_rst", 3'b000, 5'd14, 32'd7, 32'd6, 4'd1, 32'd42, 9);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
